// File: rtl/ahb_lite_wait_sram_slave.sv
// AHB-Lite SRAM responder: WAIT_STATES+1 cycle OKAY data phase, 2-cycle ERROR, byte-lane writes.
// Backpressure: HREADYOUT held low for wait/first-error cycles; HREADY low from the bus blocks capture.
module ahb_lite_wait_sram_slave #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    localparam logic [2:0] WS    = 3'(WAIT_STATES);
    localparam int         DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [DEPTH];

    logic              capture, illegal, wr_commit;
    logic [3:0]        lane_mask;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic [31:0]       wr_merged, rd_word;
    logic              unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:28]};

    assign capture = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign illegal = (HSIZE > 3'd2)
                  || (HSIZE == 3'd1 && HADDR[0])
                  || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                  || (HADDR[27:ADDR_W+2] != '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    // A capture is only possible while HREADYOUT is high, so it always overrides the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                else               state_d = ST_IDLE;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            addr_d  = HADDR[ADDR_W+1:0];
            write_d = HWRITE;
            size_d  = HSIZE[1:0];
            state_d = illegal ? ST_ERR1 : ST_WAIT;
            cnt_d   = WS;
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state_q)
            ST_WAIT: HREADYOUT = (cnt_q == 3'd0);
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    assign HRDATA = rdata_q;

    assign wr_commit = (state_q == ST_WAIT) && (cnt_q == 3'd0) && write_q;
    assign wr_idx    = addr_q[ADDR_W+1:2];

    always_comb begin
        unique case (size_q)
            2'd0:    lane_mask = 4'b0001 << addr_q[1:0];
            2'd1:    lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
        wr_merged = mem[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (lane_mask[b]) wr_merged[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    // Read data is fetched on the edge that enters the completing cycle; a write retiring on that same edge is forwarded.
    assign rd_idx  = capture ? HADDR[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    assign rd_word = (wr_commit && wr_idx == rd_idx) ? wr_merged : mem[rd_idx];

    always_comb begin
        rdata_d = '0;
        if (state_d == ST_WAIT && cnt_d == 3'd0 && !write_d) rdata_d = rd_word;
    end

    always_ff @(posedge HCLK) begin
        if (wr_commit) mem[wr_idx] <= wr_merged;
    end

endmodule

// File: tb/tb_ahb_lite_wait_sram_slave.sv
// Bench for ahb_lite_wait_sram_slave: one instance with WAIT_STATES=1, one with WAIT_STATES=0,
// driven by a pipelined master and checked cycle by cycle against a word-array memory model.
module tb_ahb_lite_wait_sram_slave;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic        bus_sel, tgt1, stall;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hsel_a, hsel_b, hready_a, hready_b;
    logic        ho_a, hr_a, ho_b, hr_b;
    logic [31:0] hd_a, hd_b;

    xfer_t       xq[$];
    logic [31:0] refm [2][64];
    logic [31:0] last_rdata;
    int          total, bad;

    assign hsel_a   = bus_sel & tgt1;
    assign hsel_b   = bus_sel & ~tgt1;
    assign hready_a = ho_a & ~stall;
    assign hready_b = ho_b & ~stall;

    ahb_lite_wait_sram_slave #(.ADDR_W(6), .WAIT_STATES(1)) u_ws1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_a), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready_a), .HWDATA(hwdata),
        .HREADYOUT(ho_a), .HRESP(hr_a), .HRDATA(hd_a)
    );

    ahb_lite_wait_sram_slave #(.ADDR_W(6), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_b), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
        .HMASTLOCK(hmastlock), .HREADY(hready_b), .HWDATA(hwdata),
        .HREADYOUT(ho_b), .HRESP(hr_b), .HRDATA(hd_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                                 input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.wr = w; x.size = s; x.wdata = d;
        return x;
    endfunction

    function automatic bit is_illegal(input xfer_t x);
        return (x.size > 3'd2)
            || (x.size == 3'd1 && x.addr[0])
            || (x.size == 3'd2 && x.addr[1:0] != 2'b00)
            || (x.addr[27:8] != 20'd0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    // Replace the 1/2/4 naturally aligned bytes the transfer covers.
    function automatic logic [31:0] merge(input logic [31:0] old, input xfer_t x);
        logic [31:0] r;
        int nb, base;
        r    = old;
        nb   = 1 << x.size;
        base = (int'(x.addr[1:0]) / nb) * nb;
        for (int b = 0; b < 4; b++)
            if (b >= base && b < base + nb) r[8*b +: 8] = x.wdata[8*b +: 8];
        return r;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int r;
        r      = $urandom_range(0, 9);
        x.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
        x.addr = {4'($urandom_range(0, 15)), 20'd0, 8'($urandom_range(0, 255))};
        if ($urandom_range(0, 9) < 8 && x.size <= 3'd2)
            x.addr[1:0] = x.addr[1:0] & ~2'((1 << x.size) - 1);
        if ($urandom_range(0, 9) == 0) x.addr[8 + $urandom_range(0, 19)] = 1'b1;
        x.wr    = 1'($urandom_range(0, 1));
        x.wdata = $urandom;
        return x;
    endfunction

    task automatic drive_idle();
        bus_sel = 1'($urandom_range(0, 1));
        htrans  = 2'($urandom_range(0, 1));
        haddr   = $urandom;
        hwrite  = 1'($urandom_range(0, 1));
        hsize   = 3'($urandom_range(0, 7));
    endtask

    // Pipelined master + memory model; every cycle compares HREADYOUT, HRESP and HRDATA.
    task automatic run_queue(input int gap_pct, input int stall_pct);
        xfer_t       ap, dp;
        bit          ap_vld, dp_vld, prev_hr, dp_ill, dp_now, exp_rdy, exp_resp;
        int          dp_i, dp_len, cyc, budget, m, w;
        logic [31:0] exp_rd, o_rd;
        logic        o_rdy, o_resp;
        ap_vld = 0; dp_vld = 0; prev_hr = 1; dp_i = 0; dp_len = 1; dp_ill = 0; cyc = 0;
        m      = tgt1 ? 1 : 0;
        budget = 12 * xq.size() + 100;
        while ((xq.size() > 0 || ap_vld || dp_vld) && cyc < budget) begin
            @(posedge clk); #1;
            if (ap_vld && prev_hr) begin
                dp = ap; dp_vld = 1; dp_i = 0; ap_vld = 0;
                dp_ill = is_illegal(dp);
                dp_len = dp_ill ? 2 : m + 1;
            end
            o_rdy  = tgt1 ? ho_a : ho_b;
            o_resp = tgt1 ? hr_a : hr_b;
            o_rd   = tgt1 ? hd_a : hd_b;
            exp_rdy = 1; exp_resp = 0; exp_rd = '0; dp_now = dp_vld; w = word_of(dp.addr);
            if (dp_vld) begin
                exp_rdy  = (dp_i == dp_len - 1);
                exp_resp = dp_ill;
                if (exp_rdy && !dp_ill && !dp.wr) exp_rd = refm[m][w];
                hwdata = dp.wdata;
            end else begin
                hwdata = $urandom;
            end
            total++;
            if (o_rdy !== exp_rdy) begin
                bad++;
                $display("FAIL hreadyout ws=%0d cyc=%0d addr=%h got=%b want=%b", m, cyc, dp.addr, o_rdy, exp_rdy);
            end
            total++;
            if (o_resp !== exp_resp) begin
                bad++;
                $display("FAIL hresp ws=%0d cyc=%0d addr=%h got=%b want=%b", m, cyc, dp.addr, o_resp, exp_resp);
            end
            total++;
            if (o_rd !== exp_rd) begin
                bad++;
                $display("FAIL hrdata ws=%0d cyc=%0d addr=%h got=%h want=%h", m, cyc, dp.addr, o_rd, exp_rd);
            end
            if (dp_vld && exp_rdy) begin
                if (!dp_ill && dp.wr)  refm[m][w] = merge(refm[m][w], dp);
                if (!dp_ill && !dp.wr) last_rdata = o_rd;
                dp_vld = 0;
            end else if (dp_vld) begin
                dp_i++;
            end
            if (!ap_vld) begin
                if (xq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                    ap      = xq.pop_front();
                    ap_vld  = 1;
                    bus_sel = 1'b1;
                    htrans  = $urandom_range(0, 1) ? 2'd2 : 2'd3;
                    haddr   = ap.addr;
                    hwrite  = ap.wr;
                    hsize   = ap.size;
                end else begin
                    drive_idle();
                end
            end
            stall   = !dp_now && ($urandom_range(0, 99) < stall_pct);
            prev_hr = o_rdy && !stall;
            cyc++;
        end
        if (xq.size() > 0 || ap_vld || dp_vld) begin
            total++; bad++;
            $display("FAIL run_queue_timeout ws=%0d got=%0d cycles want=completion", m, cyc);
            xq.delete();
        end
        bus_sel = 1'b0; htrans = 2'd0; stall = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (ho_a !== 1'b1)  begin bad++; $display("FAIL reset_hreadyout_ws1 got=%b want=1", ho_a); end
        total++; if (hr_a !== 1'b0)  begin bad++; $display("FAIL reset_hresp_ws1 got=%b want=0", hr_a); end
        total++; if (hd_a !== 32'd0) begin bad++; $display("FAIL reset_hrdata_ws1 got=%h want=0", hd_a); end
        total++; if (ho_b !== 1'b1)  begin bad++; $display("FAIL reset_hreadyout_ws0 got=%b want=1", ho_b); end
        total++; if (hr_b !== 1'b0)  begin bad++; $display("FAIL reset_hresp_ws0 got=%b want=0", hr_b); end
        total++; if (hd_b !== 32'd0) begin bad++; $display("FAIL reset_hrdata_ws0 got=%h want=0", hd_b); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int t = 0; t < 2; t++) begin
            tgt1 = (t == 0);
            for (int i = 0; i < 64; i++) xq.push_back(mk(32'(i * 4), 1'b1, 3'd2, $urandom));
            run_queue(0, 0);
        end
    endtask

    task automatic test_word_rw();
        tgt1 = 1'b1;
        xq.push_back(mk(32'h8, 1'b1, 3'd2, 32'h11223344));
        xq.push_back(mk(32'h8, 1'b0, 3'd2, 32'h0));
        run_queue(0, 0);
        total++;
        if (last_rdata !== 32'h11223344) begin bad++; $display("FAIL word_rw got=%h want=11223344", last_rdata); end
    endtask

    task automatic test_lanes();
        tgt1 = 1'b1;
        xq.push_back(mk(32'h0, 1'b1, 3'd2, 32'h0));
        xq.push_back(mk(32'h1, 1'b1, 3'd0, {8'($urandom), 8'($urandom), 8'hBB, 8'($urandom)}));
        xq.push_back(mk(32'h2, 1'b1, 3'd1, {16'hAAAA, 16'($urandom)}));
        xq.push_back(mk(32'h0, 1'b0, 3'd2, 32'h0));
        run_queue(0, 0);
        total++;
        if (last_rdata !== 32'hAAAABB00) begin bad++; $display("FAIL lanes got=%h want=AAAABB00", last_rdata); end
    endtask

    task automatic test_error();
        tgt1 = 1'b1;
        xq.push_back(mk(32'h1, 1'b1, 3'd2, 32'hDEADBEEF));
        xq.push_back(mk(32'h0, 1'b0, 3'd2, 32'h0));
        xq.push_back(mk(32'h400, 1'b0, 3'd2, 32'h0));
        xq.push_back(mk(32'h4, 1'b1, 3'd3, 32'h12345678));
        xq.push_back(mk(32'h3, 1'b1, 3'd1, 32'hFFFFFFFF));
        xq.push_back(mk(32'h1000_0000, 1'b0, 3'd2, 32'h0));
        run_queue(0, 0);
        total++;
        if (last_rdata !== 32'hAAAABB00) begin bad++; $display("FAIL error_no_write got=%h want=AAAABB00", last_rdata); end
    endtask

    task automatic test_forwarding();
        tgt1 = 1'b0;
        xq.push_back(mk(32'h10, 1'b1, 3'd2, 32'hCAFEF00D));
        xq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
        run_queue(0, 0);
        total++;
        if (last_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL forward_word got=%h want=CAFEF00D", last_rdata); end
        xq.push_back(mk(32'h11, 1'b1, 3'd0, 32'h77775A77));
        xq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
        run_queue(0, 0);
        total++;
        if (last_rdata !== 32'hCAFE5A0D) begin bad++; $display("FAIL forward_byte got=%h want=CAFE5A0D", last_rdata); end
    endtask

    task automatic test_back_to_back();
        xfer_t x;
        for (int t = 0; t < 2; t++) begin
            tgt1 = (t == 0);
            for (int i = 0; i < 20; i++) begin
                x = rand_xfer();
                x.wr = 1'b1;
                xq.push_back(x);
                x.wr = 1'b0;
                x.addr[1:0] = 2'b00;
                x.size = 3'd2;
                xq.push_back(x);
            end
            run_queue(0, 0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 2; t++) begin
            tgt1 = (t == 0);
            for (int i = 0; i < 150; i++) xq.push_back(rand_xfer());
            run_queue(25, 20);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] old;
        tgt1 = 1'b1;
        old  = refm[1][5];
        @(posedge clk); #1;
        bus_sel = 1'b1; htrans = 2'd2; haddr = 32'h14; hwrite = 1'b1; hsize = 3'd2; stall = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ho_a !== 1'b0) begin bad++; $display("FAIL rst_wait_entered got=%b want=0", ho_a); end
        hwdata = ~old; bus_sel = 1'b0; htrans = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (ho_a !== 1'b1)  begin bad++; $display("FAIL rst_async_hreadyout got=%b want=1", ho_a); end
        total++; if (hr_a !== 1'b0)  begin bad++; $display("FAIL rst_async_hresp got=%b want=0", hr_a); end
        total++; if (hd_a !== 32'd0) begin bad++; $display("FAIL rst_async_hrdata got=%h want=0", hd_a); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (ho_a !== 1'b1 || hr_a !== 1'b0) begin
            bad++; $display("FAIL rst_release_idle got=%b%b want=10", ho_a, hr_a);
        end
        xq.push_back(mk(32'h14, 1'b0, 3'd2, 32'h0));
        run_queue(0, 0);
        total++;
        if (last_rdata !== old) begin bad++; $display("FAIL rst_no_write got=%h want=%h", last_rdata, old); end
    endtask

    initial begin
        total = 0; bad = 0; last_rdata = '0;
        rst_n = 1'b0; bus_sel = 1'b0; tgt1 = 1'b1; stall = 1'b0;
        haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd0;
        hburst = 3'd0; hprot = 4'h3; hmastlock = 1'b0;
        test_reset();
        test_fill();
        test_word_rw();
        test_lanes();
        test_error();
        test_forwarding();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_wait_sram_slave.md
Name: ahb_lite_wait_sram_slave

Overview:
- AHB-Lite responder (slave) with a word-organised SRAM behind it.
- Adds the features the basic slave lacks: a configurable number of wait states, byte/halfword/word lane writes, and a two-cycle ERROR response for illegal accesses.
- Plugs into any decoder HSEL slot; its HREADYOUT/HRESP/HRDATA feed the response mux.

Parameters:
- ADDR_W, 6: word-address width; memory depth = 2^ADDR_W 32-bit words.
- WAIT_STATES, 1: HREADYOUT-low cycles inserted before each OKAY data phase completes (0..7).

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  accepted, ignored.
- HPROT  in  4  accepted, ignored.
- HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HMASTLOCK  in  1  accepted, ignored.
- HREADY  in  1  bus-level ready from the mux.
- HWDATA  in  32  write data, data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset (HRESETn low, asynchronous): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending-transfer registers cleared. Memory contents are not reset.
- Address-phase capture occurs only when HSEL && HREADY && HTRANS[1]. It latches HADDR, HWRITE and HSIZE.
- No capture for IDLE/BUSY or for an unselected slave. The next cycle then gives a zero-wait OKAY (HREADYOUT=1, HRESP=0) with no memory access.
- An access is illegal if any of the following holds:
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]≠0;
  - HADDR[27:ADDR_W+2]≠0 (out of range; HADDR[31:28] belongs to the decoder).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on a legal capture go to WAIT with counter = WAIT_STATES. If WAIT_STATES=0, the data phase completes in the next cycle directly from IDLE. On an illegal capture go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; decrement the counter each cycle. In the final data-phase cycle HREADYOUT=1 and the transfer completes. Then return to IDLE, or start a new data phase if a capture coincides.
  - ERR1: HREADYOUT=0, HRESP=1; go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Memory is not touched. A capture in this cycle is honoured; the master is expected to drive IDLE here.
- Total data-phase length: WAIT_STATES+1 cycles for OKAY, exactly 2 cycles for ERROR.
- Writes:
  - HWDATA is sampled in the completing cycle (HREADYOUT=1).
  - Little-endian byte lanes; only lanes selected by HSIZE/HADDR[1:0] are written:
    - byte: lane HADDR[1:0];
    - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
    - word: all four lanes.
- Reads:
  - HRDATA shows the full 32-bit word at index HADDR[ADDR_W+1:2] during the completing cycle; the master selects lanes.
  - HRDATA=0 in wait and error cycles.
  - HRDATA is registered; with WAIT_STATES=0 the word is fetched at the address-phase edge.
- Read-after-write: a read whose address phase overlaps the completing data phase of a write to the same word returns the merged (new) bytes. Forwarding is mandatory.
- Back-to-back pipelined transfers with no idle cycle must be sustained. HREADY low (another slave stalling) blocks capture.
- HSEL dropping mid data phase does not abort the current data phase.

Test Plan:
- WAIT_STATES=1: write word 0x11223344 to 0x0000_0008, then read 0x0000_0008 → write data phase has HREADYOUT low for 1 cycle then high; read returns 0x11223344 with HRESP=0.
- Byte write 0xBB to 0x0000_0001, then halfword write 0xAAAA to 0x0000_0002, over an initial word 0 → read 0x0000_0000 returns 0xAAAABB00.
- Word write to 0x0000_0001 → HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; a subsequent read of word 0 shows it unchanged.
- Read 0x0000_0400 with ADDR_W=6 → 2-cycle ERROR, HRDATA=0.
- WAIT_STATES=0: back-to-back write 0xCAFEF00D to 0x0000_0010 immediately followed by a read of 0x0000_0010 → read completes in the next cycle with 0xCAFEF00D (forwarding), HREADYOUT stays 1 throughout.
- Assert HRESETn low during a WAIT cycle → HREADYOUT=1, HRESP=0, HRDATA=0 immediately; FSM in IDLE after release; no memory write occurs.
